// File: rtl/vdp_sprite_writer_if.sv
// Command bus between the CPU-side register decode and vdp_sprite_writer.
//   cmd_valid  master -> slave  command valid
//   cmd_ready  slave -> master  command accepted when cmd_valid && cmd_ready
//   cmd_kind   master -> slave  00 XY, 01 ROW, 10 COMMIT, 11 reserved
//   cmd_sprite master -> slave  target sprite index
//   cmd_row    master -> slave  row index (ROW only)
//   cmd_data   master -> slave  XY word or row word
interface vdp_sprite_writer_if #(
    parameter int SPR_IDX_W = 3,
    parameter int ROW_IDX_W = 3,
    parameter int DATA_W    = 32
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_kind;
    logic [SPR_IDX_W-1:0] cmd_sprite;
    logic [ROW_IDX_W-1:0] cmd_row;
    logic [DATA_W-1:0]    cmd_data;

    modport master (
        output cmd_valid, cmd_kind, cmd_sprite, cmd_row, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_kind, cmd_sprite, cmd_row, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/vdp_sprite_writer.sv
// Tear-free sprite updater for the VDP sprite array.
// CPU commands stage one sprite's XY word and bitmap rows in shadow registers;
// a COMMIT waits for vertical blank and then replays the dirty entries, one
// write per clock (rows ascending, XY last), followed by a one-cycle done pulse.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   pixel_y        current scan line from the timing generator
//   cmd            command bus (slave side of vdp_sprite_writer_if)
//   xy_we, row_we  one-hot write enables towards the sprite instances
//   wr_row_index   row index for row writes
//   wr_data        write data
//   busy           waiting for vblank or flushing
//   done           one-cycle pulse at the end of a flush
//   err            one-cycle pulse when a command targets a different sprite
//                  than the one already staged
module vdp_sprite_writer #(
    parameter int N_SPRITES = 8,
    parameter int SPR_IDX_W = 3,
    parameter int ROWS      = 8,
    parameter int ROW_IDX_W = 3,
    parameter int DATA_W    = 32,
    parameter int Y_W       = 10,
    parameter int VBLANK_Y  = 480,
    parameter int Y_LAST    = 524
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [Y_W-1:0]        pixel_y,
    vdp_sprite_writer_if.slave    cmd,
    output logic [N_SPRITES-1:0]  xy_we,
    output logic [N_SPRITES-1:0]  row_we,
    output logic [ROW_IDX_W-1:0]  wr_row_index,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam logic [1:0]     KIND_XY     = 2'b00;
    localparam logic [1:0]     KIND_ROW    = 2'b01;
    localparam logic [1:0]     KIND_COMMIT = 2'b10;
    localparam logic [Y_W-1:0] VB_Y        = Y_W'(VBLANK_Y);
    localparam logic [Y_W-1:0] LAST_Y      = Y_W'(Y_LAST);

    typedef enum logic [1:0] {IDLE, WAIT_VB, FLUSH} state_t;

    state_t                 state_reg, state_next;
    logic                   xy_dirty_reg, xy_dirty_next;
    logic [ROWS-1:0]        row_dirty_reg, row_dirty_next;

    logic [N_SPRITES-1:0]   xy_we_reg, xy_we_next;
    logic [N_SPRITES-1:0]   row_we_reg, row_we_next;
    logic [ROW_IDX_W-1:0]   wr_row_index_reg, wr_row_index_next;
    logic [DATA_W-1:0]      wr_data_reg, wr_data_next;
    logic                   busy_reg, done_reg, done_next, err_reg, err_next;
    logic                   cmd_ready_reg;

    // Shadow staging registers; contents are meaningful only where dirty.
    logic [SPR_IDX_W-1:0]   stg_sprite_reg;
    logic [DATA_W-1:0]      stg_xy_reg;
    logic [DATA_W-1:0]      stg_row [ROWS];
    logic                   stg_sprite_we, stg_xy_we, stg_row_we;

    logic                   accept, vb_ok, any_dirty, any_row;
    logic [ROW_IDX_W-1:0]   first_row;
    logic [N_SPRITES-1:0]   spr_onehot;

    assign accept    = cmd.cmd_valid && (state_reg == IDLE);
    // The last line is excluded so a commit landing there waits for the
    // next frame's blank instead of racing the wrap to line 0.
    assign vb_ok     = (pixel_y >= VB_Y) && (pixel_y != LAST_Y);
    assign any_row   = |row_dirty_reg;
    assign any_dirty = xy_dirty_reg || any_row;

    // Lowest-index dirty row.
    always_comb begin
        first_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (row_dirty_reg[i]) begin
                first_row = ROW_IDX_W'(i);
            end
        end
    end

    always_comb begin
        spr_onehot = '0;
        spr_onehot[stg_sprite_reg] = 1'b1;
    end

    always_comb begin
        state_next        = state_reg;
        xy_dirty_next     = xy_dirty_reg;
        row_dirty_next    = row_dirty_reg;
        xy_we_next        = '0;
        row_we_next       = '0;
        wr_row_index_next = '0;
        wr_data_next      = '0;
        done_next         = 1'b0;
        err_next          = 1'b0;
        stg_sprite_we     = 1'b0;
        stg_xy_we         = 1'b0;
        stg_row_we        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (cmd.cmd_kind == KIND_XY || cmd.cmd_kind == KIND_ROW) begin
                        // A clean stage adopts the new sprite; a dirty one
                        // only accepts further data for the same sprite.
                        if (!any_dirty || cmd.cmd_sprite == stg_sprite_reg) begin
                            stg_sprite_we = 1'b1;
                            if (cmd.cmd_kind == KIND_XY) begin
                                stg_xy_we     = 1'b1;
                                xy_dirty_next = 1'b1;
                            end else begin
                                stg_row_we                  = 1'b1;
                                row_dirty_next[cmd.cmd_row] = 1'b1;
                            end
                        end else begin
                            err_next = 1'b1;
                        end
                    end else if (cmd.cmd_kind == KIND_COMMIT) begin
                        state_next = WAIT_VB;
                    end
                end
            end

            WAIT_VB, FLUSH: begin
                // The first write is issued on the same edge that samples
                // vb_ok, so it is visible the cycle right after.
                if (state_reg == FLUSH || vb_ok) begin
                    if (any_row) begin
                        row_we_next               = spr_onehot;
                        wr_row_index_next         = first_row;
                        wr_data_next              = stg_row[first_row];
                        row_dirty_next[first_row] = 1'b0;
                        state_next                = FLUSH;
                    end else if (xy_dirty_reg) begin
                        // XY last: a newly enabled sprite never shows stale rows.
                        xy_we_next    = spr_onehot;
                        wr_data_next  = stg_xy_reg;
                        xy_dirty_next = 1'b0;
                        state_next    = FLUSH;
                    end else begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            xy_dirty_reg     <= 1'b0;
            row_dirty_reg    <= '0;
            xy_we_reg        <= '0;
            row_we_reg       <= '0;
            wr_row_index_reg <= '0;
            wr_data_reg      <= '0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            err_reg          <= 1'b0;
            cmd_ready_reg    <= 1'b1;
        end else begin
            state_reg        <= state_next;
            xy_dirty_reg     <= xy_dirty_next;
            row_dirty_reg    <= row_dirty_next;
            xy_we_reg        <= xy_we_next;
            row_we_reg       <= row_we_next;
            wr_row_index_reg <= wr_row_index_next;
            wr_data_reg      <= wr_data_next;
            busy_reg         <= (state_next != IDLE);
            done_reg         <= done_next;
            err_reg          <= err_next;
            cmd_ready_reg    <= (state_next == IDLE);
        end
    end

    // Staging data carries no reset; the dirty bits qualify it.
    always_ff @(posedge clk) begin
        if (stg_sprite_we) begin
            stg_sprite_reg <= cmd.cmd_sprite;
        end
        if (stg_xy_we) begin
            stg_xy_reg <= cmd.cmd_data;
        end
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_stg_row
        always_ff @(posedge clk) begin
            if (stg_row_we && cmd.cmd_row == ROW_IDX_W'(gi)) begin
                stg_row[gi] <= cmd.cmd_data;
            end
        end
    end

    assign cmd.cmd_ready = cmd_ready_reg;
    assign xy_we         = xy_we_reg;
    assign row_we        = row_we_reg;
    assign wr_row_index  = wr_row_index_reg;
    assign wr_data       = wr_data_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign err           = err_reg;
endmodule
